// File: rtl/multicycle_sequencer.sv
// Multicycle instruction sequencer: FETCH/DECODE/EXEC/MEM/WB control with registered outputs.
// Define SEQ_TIMEOUT_EN to bound the MEM wait to MEM_TIMEOUT cycles before entering ERROR.
module multicycle_sequencer #(
    parameter int MEM_TIMEOUT = 8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [22:0] instr,
    input  logic        mem_ack,
    input  logic        zero,
    output logic [11:0] pc,
    output logic        ir_load,
    output logic        reg_write,
    output logic        reg_dst,
    output logic        alu_src,
    output logic        mem_to_reg,
    output logic [2:0]  alu_op,
    output logic        mem_req,
    output logic        mem_we,
    output logic        busy,
    output logic        halted,
    output logic        err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_HALT,
        S_ERROR
    } state_t;

    localparam logic [4:0] OP_NOP  = 5'b00000;
    localparam logic [4:0] OP_ADD  = 5'b00001;
    localparam logic [4:0] OP_SUB  = 5'b00010;
    localparam logic [4:0] OP_AND  = 5'b00011;
    localparam logic [4:0] OP_OR   = 5'b00100;
    localparam logic [4:0] OP_ADDI = 5'b00101;
    localparam logic [4:0] OP_LW   = 5'b00110;
    localparam logic [4:0] OP_SW   = 5'b00111;
    localparam logic [4:0] OP_BEQ  = 5'b01000;
    localparam logic [4:0] OP_J    = 5'b01001;
    localparam logic [4:0] OP_HALT = 5'b11111;

    state_t      state;
    state_t      state_nxt;
    logic [4:0]  ir_op;
    logic [11:0] ir_off;
    logic [11:0] pc_nxt;

    logic        ir_load_nxt;
    logic        reg_write_nxt;
    logic        reg_dst_nxt;
    logic        alu_src_nxt;
    logic        mem_to_reg_nxt;
    logic [2:0]  alu_op_nxt;
    logic        mem_req_nxt;
    logic        mem_we_nxt;
    logic        busy_nxt;
    logic        halted_nxt;
    logic        err_nxt;

    // Register-select fields are consumed by the datapath, not by the sequencer.
    logic unused_fields;

    function automatic logic [2:0] alu_sel(input logic [4:0] op);
        case (op)
            OP_SUB, OP_BEQ: alu_sel = 3'b001;
            OP_AND:         alu_sel = 3'b010;
            OP_OR:          alu_sel = 3'b011;
            default:        alu_sel = 3'b000;
        endcase
    endfunction

    function automatic logic is_rtype(input logic [4:0] op);
        is_rtype = (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) || (op == OP_OR);
    endfunction

    function automatic logic uses_imm(input logic [4:0] op);
        uses_imm = (op == OP_ADDI) || (op == OP_LW) || (op == OP_SW);
    endfunction

`ifdef SEQ_TIMEOUT_EN
    localparam int TW = $clog2(MEM_TIMEOUT + 1);
    logic [TW-1:0] tcnt;
    logic          mem_expired;

    assign mem_expired = (tcnt == TW'(MEM_TIMEOUT - 1));
    assign unused_fields = ^instr[17:12];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            tcnt <= '0;
        end else if (state == S_MEM && state_nxt == S_MEM) begin
            tcnt <= tcnt + 1'b1;
        end else begin
            tcnt <= '0;
        end
    end
`else
    assign unused_fields = ^{instr[17:12], MEM_TIMEOUT[0]};
`endif

    // Instruction register: data only, captured while FETCH drives ir_load.
    always_ff @(posedge clock) begin
        if (state == S_FETCH) begin
            ir_op  <= instr[22:18];
            ir_off <= instr[11:0];
        end
    end

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = S_FETCH;
                    pc_nxt    = '0;
                end
            end
            S_FETCH: state_nxt = S_DECODE;
            S_DECODE: begin
                case (ir_op)
                    OP_NOP: begin
                        state_nxt = S_FETCH;
                        pc_nxt    = pc + 12'd1;
                    end
                    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ADDI,
                    OP_LW, OP_SW, OP_BEQ, OP_J: state_nxt = S_EXEC;
                    OP_HALT: state_nxt = S_HALT;
                    default: state_nxt = S_ERROR;
                endcase
            end
            S_EXEC: begin
                case (ir_op)
                    OP_BEQ: begin
                        state_nxt = S_FETCH;
                        pc_nxt    = zero ? (pc + 12'd1 + ir_off) : (pc + 12'd1);
                    end
                    OP_J: begin
                        state_nxt = S_FETCH;
                        pc_nxt    = ir_off;
                    end
                    OP_LW, OP_SW: state_nxt = S_MEM;
                    default:      state_nxt = S_WB;
                endcase
            end
            S_MEM: begin
                if (mem_ack) begin
                    if (ir_op == OP_SW) begin
                        state_nxt = S_FETCH;
                        pc_nxt    = pc + 12'd1;
                    end else begin
                        state_nxt = S_WB;
                    end
                end
`ifdef SEQ_TIMEOUT_EN
                else if (mem_expired) begin
                    state_nxt = S_ERROR;
                end
`endif
            end
            S_WB: begin
                state_nxt = S_FETCH;
                pc_nxt    = pc + 12'd1;
            end
            S_HALT:  state_nxt = S_HALT;
            S_ERROR: state_nxt = S_ERROR;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Outputs are decoded from the state being entered so they register alongside it.
    always_comb begin
        ir_load_nxt    = 1'b0;
        reg_write_nxt  = 1'b0;
        reg_dst_nxt    = 1'b0;
        alu_src_nxt    = 1'b0;
        mem_to_reg_nxt = 1'b0;
        alu_op_nxt     = 3'b000;
        mem_req_nxt    = 1'b0;
        mem_we_nxt     = 1'b0;
        busy_nxt       = 1'b1;
        halted_nxt     = 1'b0;
        err_nxt        = 1'b0;
        case (state_nxt)
            S_IDLE:  busy_nxt = 1'b0;
            S_FETCH: ir_load_nxt = 1'b1;
            S_EXEC: begin
                alu_op_nxt  = alu_sel(ir_op);
                alu_src_nxt = uses_imm(ir_op);
            end
            S_MEM: begin
                alu_op_nxt  = alu_sel(ir_op);
                mem_req_nxt = 1'b1;
                mem_we_nxt  = (ir_op == OP_SW);
            end
            S_WB: begin
                alu_op_nxt     = alu_sel(ir_op);
                reg_write_nxt  = 1'b1;
                reg_dst_nxt    = is_rtype(ir_op);
                mem_to_reg_nxt = (ir_op == OP_LW);
            end
            S_HALT: begin
                busy_nxt   = 1'b0;
                halted_nxt = 1'b1;
            end
            S_ERROR: begin
                busy_nxt = 1'b0;
                err_nxt  = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            pc         <= '0;
            ir_load    <= 1'b0;
            reg_write  <= 1'b0;
            reg_dst    <= 1'b0;
            alu_src    <= 1'b0;
            mem_to_reg <= 1'b0;
            alu_op     <= 3'b000;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            busy       <= 1'b0;
            halted     <= 1'b0;
            err        <= 1'b0;
        end else begin
            state      <= state_nxt;
            pc         <= pc_nxt;
            ir_load    <= ir_load_nxt;
            reg_write  <= reg_write_nxt;
            reg_dst    <= reg_dst_nxt;
            alu_src    <= alu_src_nxt;
            mem_to_reg <= mem_to_reg_nxt;
            alu_op     <= alu_op_nxt;
            mem_req    <= mem_req_nxt;
            mem_we     <= mem_we_nxt;
            busy       <= busy_nxt;
            halted     <= halted_nxt;
            err        <= err_nxt;
        end
    end

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Directed bench for multicycle_sequencer: instruction paths, pc wrap, memory handshake, error/halt, async reset.
module tb_multicycle_sequencer;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [22:0] instr = '0;
    logic        mem_ack = 1'b0;
    logic        zero = 1'b0;
    logic [11:0] pc;
    logic        ir_load, reg_write, reg_dst, alu_src, mem_to_reg;
    logic [2:0]  alu_op;
    logic        mem_req, mem_we, busy, halted, err;
    logic [9:0]  ctl;

    int vectors = 0;
    int miscompares = 0;

    multicycle_sequencer #(.MEM_TIMEOUT(8)) dut (
        .clock(clock), .reset(reset), .start(start), .instr(instr),
        .mem_ack(mem_ack), .zero(zero), .pc(pc), .ir_load(ir_load),
        .reg_write(reg_write), .reg_dst(reg_dst), .alu_src(alu_src),
        .mem_to_reg(mem_to_reg), .alu_op(alu_op), .mem_req(mem_req),
        .mem_we(mem_we), .busy(busy), .halted(halted), .err(err)
    );

    always #5 clock = ~clock;

    assign ctl = {ir_load, reg_write, reg_dst, alu_src, mem_to_reg, mem_req, mem_we, alu_op};

    function automatic logic [9:0] c(input logic il, input logic rw, input logic rd,
                                     input logic as, input logic m2r, input logic mq,
                                     input logic mw, input logic [2:0] op);
        return {il, rw, rd, as, m2r, mq, mw, op};
    endfunction

    function automatic logic [22:0] mk(input logic [4:0] op, input logic [11:0] off);
        return {op, 6'b000000, off};
    endfunction

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tick(2);
        check("rst_pc", 32'(pc), 32'h000);
        check("rst_ctl", 32'(ctl), 32'h0);
        check("rst_flags", 32'({busy, halted, err}), 32'b000);

        // ADD at pc=0, mem_ack held high to show it is ignored outside MEM
        reset = 1'b0; start = 1'b1; instr = mk(5'b00001, 12'h000); mem_ack = 1'b1;
        tick(1);
        check("add_fetch", 32'(ctl), 32'(c(1,0,0,0,0,0,0,3'b000)));
        check("add_busy", 32'(busy), 32'h1);
        start = 1'b0;
        tick(1);
        check("add_decode", 32'(ctl), 32'h0);
        instr = mk(5'b00110, 12'h000);
        tick(1);
        check("add_exec", 32'(ctl), 32'(c(0,0,0,0,0,0,0,3'b000)));
        tick(1);
        check("add_wb", 32'(ctl), 32'(c(0,1,1,0,0,0,0,3'b000)));
        mem_ack = 1'b0;
        tick(1);
        check("add_pc", 32'(pc), 32'h001);
        check("add_next_fetch", 32'(ctl), 32'(c(1,0,0,0,0,0,0,3'b000)));

        // LW with ack in the 4th MEM cycle: 8 cycles total
        tick(2);
        check("lw_exec", 32'(ctl), 32'(c(0,0,0,1,0,0,0,3'b000)));
        for (int i = 0; i < 4; i++) begin
            tick(1);
            check("lw_mem", 32'(ctl), 32'(c(0,0,0,0,0,1,0,3'b000)));
            if (i == 3) mem_ack = 1'b1;
        end
        tick(1);
        mem_ack = 1'b0;
        check("lw_wb", 32'(ctl), 32'(c(0,1,0,0,1,0,0,3'b000)));
        tick(1);
        check("lw_pc", 32'(pc), 32'h002);
        instr = mk(5'b00111, 12'h000);

        // SW with immediate ack
        tick(2);
        check("sw_exec", 32'(ctl), 32'(c(0,0,0,1,0,0,0,3'b000)));
        tick(1);
        check("sw_mem", 32'(ctl), 32'(c(0,0,0,0,0,1,1,3'b000)));
        mem_ack = 1'b1;
        instr = mk(5'b01001, 12'hFFE);
        tick(1);
        mem_ack = 1'b0;
        check("sw_pc", 32'(pc), 32'h003);
        check("sw_no_write", 32'(ctl), 32'(c(1,0,0,0,0,0,0,3'b000)));

        // J to 0xFFE, then BEQ taken with wrap
        tick(3);
        check("j_pc", 32'(pc), 32'hFFE);
        instr = mk(5'b01000, 12'h005); zero = 1'b1;
        tick(2);
        check("beq_exec", 32'(ctl), 32'(c(0,0,0,0,0,0,0,3'b001)));
        tick(1);
        check("beq_taken_pc", 32'(pc), 32'h004);
        zero = 1'b0; instr = mk(5'b01001, 12'hFFE);
        tick(3);
        check("j2_pc", 32'(pc), 32'hFFE);
        instr = mk(5'b01000, 12'h005);
        tick(3);
        check("beq_not_taken_pc", 32'(pc), 32'hFFF);

        // NOP wraps pc 0xFFF -> 0x000 in 2 cycles
        instr = mk(5'b00000, 12'h000);
        tick(2);
        check("nop_wrap_pc", 32'(pc), 32'h000);
        check("nop_fetch", 32'(ir_load), 32'h1);

        // ADDI
        instr = mk(5'b00101, 12'h000);
        tick(2);
        check("addi_exec", 32'(ctl), 32'(c(0,0,0,1,0,0,0,3'b000)));
        tick(1);
        check("addi_wb", 32'(ctl), 32'(c(0,1,0,0,0,0,0,3'b000)));
        tick(1);
        check("addi_pc", 32'(pc), 32'h001);

        // Illegal opcode at pc=1
        instr = mk(5'b10101, 12'h000);
        tick(2);
        check("err_flags", 32'({busy, halted, err}), 32'b001);
        check("err_pc", 32'(pc), 32'h001);
        check("err_ctl", 32'(ctl), 32'h0);
        start = 1'b1;
        tick(3);
        check("err_absorb", 32'({busy, halted, err}), 32'b001);
        check("err_absorb_pc", 32'(pc), 32'h001);
        start = 1'b0;

        // Async reset while a LW waits in MEM
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        check("rst2_clear", 32'({pc, busy, halted, err}), 32'h0);
        start = 1'b1; instr = mk(5'b00000, 12'h000);
        tick(1);
        start = 1'b0;
        tick(1);
        instr = mk(5'b00110, 12'h000);
        tick(4);
        tick(1);
        check("mid_mem_req", 32'({mem_req, pc}), 32'h1001);
        #3 reset = 1'b1;
        #1;
        check("async_ctl", 32'(ctl), 32'h0);
        check("async_state", 32'({pc, busy, halted, err}), 32'h0);
        tick(1);
        reset = 1'b0;
        tick(2);
        check("post_rst_idle", 32'({busy, reg_write, ctl}), 32'h0);

        // HALT at pc=1
        start = 1'b1; instr = mk(5'b00000, 12'h000);
        tick(1);
        start = 1'b0;
        tick(1);
        instr = mk(5'b11111, 12'h000);
        tick(2);
        tick(1);
        check("halt_flags", 32'({busy, halted, err}), 32'b010);
        check("halt_pc", 32'(pc), 32'h001);
        start = 1'b1;
        tick(3);
        check("halt_absorb", 32'({busy, halted, err, ctl}), 32'(13'b0_1_0_0000000000));
        check("halt_absorb_pc", 32'(pc), 32'h001);
        start = 1'b0;

`ifdef SEQ_TIMEOUT_EN
        // SW without ack: ERROR after 8 MEM cycles
        reset = 1'b1;
        tick(1);
        reset = 1'b0; start = 1'b1; instr = mk(5'b00111, 12'h000);
        tick(1);
        start = 1'b0;
        tick(2);
        for (int i = 0; i < 8; i++) begin
            tick(1);
            check("to_mem_req", 32'({mem_req, mem_we}), 32'b11);
        end
        tick(1);
        check("to_err", 32'({busy, err, mem_req}), 32'b010);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
